micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microprogram sequencer for the multicycle MIPS control path. It holds the micro-PC (uPC) and a 10-word control store, and dispatches on the IR opcode.
- It drives the datapath strobes directly. It also emits the 3-bit Code field that the downstream control decoder expands into MemWr/IRWr/MemtoReg/PCSrc/RegDst.
- It stalls on memory steps until the memory signals ready. It flags unsupported opcodes and counts retired instructions.

Parameters:
- UPC_W, 4, micro-PC width (control store depth 2^UPC_W; words 10..15 behave as word 0 with all strobes 0 and Seq=fetch).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Op  in  6  IR[31:26]. Stable from the cycle after fetch completes.
- MemReady  in  1  memory access completes this cycle.
- uPC  out  UPC_W  current micro-address (registered).
- Code  out  3  encoded field for the control decoder.
- PCWr  out  1  unconditional PC write.
- PCWrCond  out  1  PC write if ALU zero.
- IorD  out  1  memory address select (0=PC, 1=ALUOut).
- MemRd  out  1  memory read.
- RegWr  out  1  register file write.
- ALUSrcA  out  1  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ALUOp  out  2  ALU operation class.
- IllegalOp  out  1  sticky unsupported-opcode flag.
- Retired  out  CNT_W  completed-instruction count.

Behaviour:
- While rst is high: uPC=0, IllegalOp=0, Retired=0. PCWr, PCWrCond, RegWr and MemRd are forced 0, and Code is forced 000. ALU fields show word 0 values.
- Control outputs are combinational from uPC, valid in the same cycle. uPC updates on the rising edge.

Code encoding:
- 000 none
- 001 RegDst
- 010 PCSrc=branch
- 011 PCSrc=jump
- 100 MemtoReg
- 101 MemWr
- 110 IRWr

Control store (word: active strobes; Code; Seq; Wait):
- 0 Fetch: MemRd, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWr; Code 110; next; wait.
- 1 Decode: ALUSrcA=0, ALUSrcB=11, ALUOp=00; Code 000; dispatch1.
- 2 MemAddr: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Code 000; dispatch2.
- 3 LwRead: MemRd, IorD=1; Code 000; next; wait.
- 4 LwWB: RegWr; Code 100; fetch.
- 5 SwWrite: IorD=1; Code 101; fetch; wait.
- 6 RExec: ALUSrcA=1, ALUSrcB=00, ALUOp=10; Code 000; next.
- 7 RWB: RegWr; Code 001; fetch.
- 8 Beq: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrCond; Code 010; fetch.
- 9 Jump: PCWr; Code 011; fetch.
- Any field not listed in a word is 0.

Sequencing:
- next: uPC+1.
- fetch: uPC=0.
- dispatch1 on Op: 000000→6, 100011→2, 101011→2, 000100→8, 000010→9. Any other Op → 0, and IllegalOp is set to 1.
- dispatch2 on Op: 100011→3, 101011→5, any other Op → 0.

Wait handshake:
- In a wait word with MemReady=0, uPC holds.
- During that stall, PCWr, PCWrCond and RegWr are forced 0 and Code is forced 000. MemRd, IorD and the ALU fields stay asserted.
- Strobes fire only in the cycle MemReady=1; uPC advances at the end of that cycle.
- MemReady is ignored in non-wait words.

Retired counter:
- Increments by 1 on every edge where a Seq=fetch word advances (including a wait word that completes).
- Wraps modulo 2^CNT_W.
- Illegal dispatch does not increment it.

IllegalOp:
- Sticky until rst.

Reset mid-instruction:
- uPC returns to 0 immediately (asynchronous). Strobes drop in the same cycle.

Test Plan:
- Reset asserted while uPC=7 → uPC=0, RegWr=0, Code=000 without waiting for a clock edge; after release, word 0 with PCWr=1, Code=110 when MemReady=1.
- lw (Op=100011), MemReady=1 always → uPC sequence 0,1,2,3,4,0; Code 110,000,000,000,100; RegWr=1 only at uPC=4; Retired 0→1.
- sw (Op=101011), MemReady=0 for two cycles at uPC=5 → uPC holds at 5; IorD=1 and Code=000 for two cycles, then Code=101 for one cycle; then uPC=0 and Retired+1.
- beq (Op=000100) → uPC 0,1,8,0; at uPC=8: PCWrCond=1, ALUOp=01, Code=010.
- Op=111111 → uPC 0,1,0; IllegalOp=1 and stays 1 through a following R-type (Op=000000: 0,1,6,7,0, Code 001 at 7); Retired increments only for the R-type.
- Fetch stall of 3 cycles (MemReady=0) → uPC holds at 0; PCWr=0 and Code=000 while MemRd=1; PCWr=1 and Code=110 asserted exactly once, on the ready cycle.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the multicycle MIPS control path.
// Holds the micro-PC and a 10-word control store, and dispatches on the opcode.
module micro_sequencer #(
    parameter int UPC_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic             MemReady,
    output logic [UPC_W-1:0] uPC,
    output logic [2:0]       Code,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             RegWr,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [1:0] {
        SQ_NEXT,
        SQ_FETCH,
        SQ_D1,
        SQ_D2
    } seq_t;

    logic       w_pcwr, w_pcwrc, w_iord, w_memrd, w_regwr, w_srca, w_wait;
    logic [1:0] w_srcb, w_aluop;
    logic [2:0] w_code;
    seq_t       w_seq;

    logic [UPC_W-1:0] nxt;
    logic             illegal;
    logic             stall;
    logic             kill;

    always_comb begin
        w_pcwr  = 1'b0;
        w_pcwrc = 1'b0;
        w_iord  = 1'b0;
        w_memrd = 1'b0;
        w_regwr = 1'b0;
        w_srca  = 1'b0;
        w_srcb  = 2'b00;
        w_aluop = 2'b00;
        w_code  = 3'b000;
        w_seq   = SQ_FETCH;
        w_wait  = 1'b0;
        case (uPC)
            UPC_W'(0): begin
                w_memrd = 1'b1;
                w_srcb  = 2'b01;
                w_pcwr  = 1'b1;
                w_code  = 3'b110;
                w_seq   = SQ_NEXT;
                w_wait  = 1'b1;
            end
            UPC_W'(1): begin
                w_srcb = 2'b11;
                w_seq  = SQ_D1;
            end
            UPC_W'(2): begin
                w_srca = 1'b1;
                w_srcb = 2'b10;
                w_seq  = SQ_D2;
            end
            UPC_W'(3): begin
                w_memrd = 1'b1;
                w_iord  = 1'b1;
                w_seq   = SQ_NEXT;
                w_wait  = 1'b1;
            end
            UPC_W'(4): begin
                w_regwr = 1'b1;
                w_code  = 3'b100;
            end
            UPC_W'(5): begin
                w_iord = 1'b1;
                w_code = 3'b101;
                w_wait = 1'b1;
            end
            UPC_W'(6): begin
                w_srca  = 1'b1;
                w_aluop = 2'b10;
                w_seq   = SQ_NEXT;
            end
            UPC_W'(7): begin
                w_regwr = 1'b1;
                w_code  = 3'b001;
            end
            UPC_W'(8): begin
                w_srca  = 1'b1;
                w_aluop = 2'b01;
                w_pcwrc = 1'b1;
                w_code  = 3'b010;
            end
            UPC_W'(9): begin
                w_pcwr = 1'b1;
                w_code = 3'b011;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt     = '0;
        illegal = 1'b0;
        unique case (w_seq)
            SQ_NEXT:  nxt = uPC + UPC_W'(1);
            SQ_FETCH: nxt = '0;
            SQ_D1: begin
                case (Op)
                    6'b000000: nxt = UPC_W'(6);
                    6'b100011: nxt = UPC_W'(2);
                    6'b101011: nxt = UPC_W'(2);
                    6'b000100: nxt = UPC_W'(8);
                    6'b000010: nxt = UPC_W'(9);
                    default:   illegal = 1'b1;
                endcase
            end
            SQ_D2: begin
                case (Op)
                    6'b100011: nxt = UPC_W'(3);
                    6'b101011: nxt = UPC_W'(5);
                    default:   nxt = '0;
                endcase
            end
        endcase
    end

    // A stalled memory step must not commit any architectural write.
    assign stall    = w_wait & ~MemReady;
    assign kill     = rst | stall;
    assign PCWr     = w_pcwr & ~kill;
    assign PCWrCond = w_pcwrc & ~kill;
    assign RegWr    = w_regwr & ~kill;
    assign Code     = kill ? 3'b000 : w_code;
    assign MemRd    = w_memrd & ~rst;
    assign IorD     = w_iord;
    assign ALUSrcA  = w_srca;
    assign ALUSrcB  = w_srcb;
    assign ALUOp    = w_aluop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uPC       <= '0;
            IllegalOp <= 1'b0;
            Retired   <= '0;
        end else if (!stall) begin
            uPC <= nxt;
            if (illegal)
                IllegalOp <= 1'b1;
            if (w_seq == SQ_FETCH)
                Retired <= Retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a reference model pushes expected
// per-cycle outputs and a negedge monitor pops and compares them.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Op;
    logic        MemReady;
    logic [3:0]  uPC;
    logic [2:0]  Code;
    logic        PCWr, PCWrCond, IorD, MemRd, RegWr, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp;
    logic        IllegalOp;
    logic [31:0] Retired;

    micro_sequencer #(.UPC_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
        .uPC(uPC), .Code(Code), .PCWr(PCWr), .PCWrCond(PCWrCond),
        .IorD(IorD), .MemRd(MemRd), .RegWr(RegWr), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
        .Retired(Retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  upc;
        logic [2:0]  code;
        logic [9:0]  strb;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    // {PCWr,PCWrCond,IorD,MemRd,RegWr,ALUSrcA,ALUSrcB,ALUOp}
    logic [9:0] t_strb [10];
    logic [2:0] t_code [10];
    logic [3:0] m_upc;
    logic       m_ill;
    logic [31:0] m_ret;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_wait(input logic [3:0] w);
        return w == 4'd0 || w == 4'd3 || w == 4'd5;
    endfunction

    function automatic bit is_fetch(input logic [3:0] w);
        return w == 4'd4 || w == 4'd5 || w == 4'd7 || w == 4'd8 || w == 4'd9;
    endfunction

    task automatic step(input logic [5:0] op, input logic rdy);
        exp_t e;
        logic stl;
        @(posedge clk);
        #1;
        Op = op;
        MemReady = rdy;
        stl = is_wait(m_upc) && !rdy;
        e.upc  = m_upc;
        e.code = stl ? 3'b000 : t_code[m_upc];
        e.strb = t_strb[m_upc];
        if (stl)
            e.strb = e.strb & 10'b00_1_1_0_1_11_11;
        e.ill  = m_ill;
        e.ret  = m_ret;
        sb.push_back(e);
        if (!stl) begin
            if (is_fetch(m_upc))
                m_ret = m_ret + 1;
            case (m_upc)
                4'd1: begin
                    if (op == 6'b000000) m_upc = 4'd6;
                    else if (op == 6'b100011 || op == 6'b101011) m_upc = 4'd2;
                    else if (op == 6'b000100) m_upc = 4'd8;
                    else if (op == 6'b000010) m_upc = 4'd9;
                    else begin
                        m_upc = 4'd0;
                        m_ill = 1'b1;
                    end
                end
                4'd2: m_upc = (op == 6'b100011) ? 4'd3 :
                              (op == 6'b101011) ? 4'd5 : 4'd0;
                4'd0, 4'd3, 4'd6: m_upc = m_upc + 4'd1;
                default: m_upc = 4'd0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("upc", 64'(uPC), 64'(e.upc));
            check("code", 64'(Code), 64'(e.code));
            check("strobes", 64'({PCWr, PCWrCond, IorD, MemRd, RegWr,
                                  ALUSrcA, ALUSrcB, ALUOp}), 64'(e.strb));
            check("illegal", 64'(IllegalOp), 64'(e.ill));
            check("retired", 64'(Retired), 64'(e.ret));
        end
    end

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] RT = 6'b000000, JMP = 6'b000010, BAD = 6'b111111;

    initial begin
        t_strb[0] = 10'b1_0_0_1_0_0_01_00; t_code[0] = 3'b110;
        t_strb[1] = 10'b0_0_0_0_0_0_11_00; t_code[1] = 3'b000;
        t_strb[2] = 10'b0_0_0_0_0_1_10_00; t_code[2] = 3'b000;
        t_strb[3] = 10'b0_0_1_1_0_0_00_00; t_code[3] = 3'b000;
        t_strb[4] = 10'b0_0_0_0_1_0_00_00; t_code[4] = 3'b100;
        t_strb[5] = 10'b0_0_1_0_0_0_00_00; t_code[5] = 3'b101;
        t_strb[6] = 10'b0_0_0_0_0_1_00_10; t_code[6] = 3'b000;
        t_strb[7] = 10'b0_0_0_0_1_0_00_00; t_code[7] = 3'b001;
        t_strb[8] = 10'b0_1_0_0_0_1_00_01; t_code[8] = 3'b010;
        t_strb[9] = 10'b1_0_0_0_0_0_00_00; t_code[9] = 3'b011;
        m_upc = 4'd0;
        m_ill = 1'b0;
        m_ret = 32'd0;

        rst = 1'b1;
        Op = 6'd0;
        MemReady = 1'b1;
        #3;
        check("rst_upc", 64'(uPC), 64'd0);
        check("rst_memrd", 64'(MemRd), 64'd0);
        check("rst_pcwr", 64'(PCWr), 64'd0);
        check("rst_code", 64'(Code), 64'd0);
        check("rst_ill", 64'(IllegalOp), 64'd0);
        check("rst_ret", 64'(Retired), 64'd0);
        MemReady = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (5) step(LW, 1'b1);
        step(SW, 1'b1); step(SW, 1'b1); step(SW, 1'b1);
        step(SW, 1'b0); step(SW, 1'b0); step(SW, 1'b1);
        repeat (3) step(BEQ, 1'b1);
        repeat (2) step(BAD, 1'b1);
        repeat (4) step(RT, 1'b1);
        repeat (3) step(RT, 1'b0);
        repeat (4) step(RT, 1'b1);
        repeat (4) step(RT, 1'b1);

        // uPC is now 7: reset must take effect between clock edges.
        #6;
        check("pre_rst_upc", 64'(uPC), 64'd7);
        rst = 1'b1;
        #1;
        check("arst_upc", 64'(uPC), 64'd0);
        check("arst_regwr", 64'(RegWr), 64'd0);
        check("arst_code", 64'(Code), 64'd0);
        check("arst_ill", 64'(IllegalOp), 64'd0);
        check("arst_ret", 64'(Retired), 64'd0);
        m_upc = 4'd0;
        m_ill = 1'b0;
        m_ret = 32'd0;
        MemReady = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (3) step(JMP, 1'b1);
        step(JMP, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
